// File: rtl/cam_tc_sequencer_if.sv
// Bundle of the job, load, query, CAM command/response and result streams
// seen by the triangle-counting CAM sequencer.
// Ports: slave = sequencer side, master = job/data source and CAM side.
`timescale 1ns/1ps
interface cam_tc_sequencer_if #(
  parameter int C_DATA_WIDTH = 520,
  parameter int BEAT_W       = 4,
  parameter int CNT_WIDTH    = 64
);
  // job descriptor
  logic                    job_valid;
  logic                    job_ready;
  logic [BEAT_W-1:0]       job_load_beats;
  logic [31:0]             job_query_cnt;
  // adjacency load stream
  logic                    ld_tvalid;
  logic                    ld_tready;
  logic [511:0]            ld_tdata;
  // query key stream
  logic                    q_tvalid;
  logic                    q_tready;
  logic [31:0]             q_tdata;
  // CAM command / response
  logic                    cam_s_tvalid;
  logic [C_DATA_WIDTH-1:0] cam_s_tdata;
  logic                    cam_m_tvalid;
  logic [C_DATA_WIDTH-1:0] cam_m_tdata;
  // job result
  logic                    done_valid;
  logic [CNT_WIDTH-1:0]    done_count;
  logic                    done_ready;

  modport slave (
    input  job_valid, job_load_beats, job_query_cnt,
    output job_ready,
    input  ld_tvalid, ld_tdata,
    output ld_tready,
    input  q_tvalid, q_tdata,
    output q_tready,
    output cam_s_tvalid, cam_s_tdata,
    input  cam_m_tvalid, cam_m_tdata,
    output done_valid, done_count,
    input  done_ready
  );

  modport master (
    output job_valid, job_load_beats, job_query_cnt,
    input  job_ready,
    output ld_tvalid, ld_tdata,
    input  ld_tready,
    output q_tvalid, q_tdata,
    input  q_tready,
    input  cam_s_tvalid, cam_s_tdata,
    output cam_m_tvalid, cam_m_tdata,
    input  done_valid, done_count,
    output done_ready
  );
endinterface

// File: rtl/cam_tc_sequencer.sv
// Per-job CAM sequencer for triangle counting: CLEAR, LOAD adjacency, QUERY keys, EOS, count hits.
// Latency: load/query beats pass through to the CAM command in the same cycle; result after EOS echo.
// Backpressure: ld/q ready only in LOAD/QUERY, never stalled by the CAM; result held until done_ready.
// Ports: aclk, areset (async, active high), io (slave side of cam_tc_sequencer_if).
`timescale 1ns/1ps
module cam_tc_sequencer #(
  parameter int C_DATA_WIDTH = 520,
  parameter int CAM_SIZE     = 128,
  parameter int LANES        = 16,
  parameter int BEAT_W       = $clog2(CAM_SIZE/LANES)+1,
  parameter int CNT_WIDTH    = 64
) (
  input  logic               aclk,
  input  logic               areset,
  cam_tc_sequencer_if.slave  io
);

  // CAM state-field codes carried in command bits [518:515]
  localparam logic [3:0] CODE_IDLE      = 4'h0;
  localparam logic [3:0] CODE_SEARCH    = 4'h5;
  localparam logic [3:0] CODE_RESET_ALL = 4'h7;
  localparam logic [3:0] CODE_WRITE     = 4'h8;
  localparam logic [3:0] CODE_EOS       = 4'hF;

  localparam logic [BEAT_W-1:0] MAX_BEATS = BEAT_W'(CAM_SIZE/LANES);

  typedef enum logic [2:0] {
    S_IDLE, S_CLEAR, S_LOAD, S_QUERY, S_EOS, S_FLUSH, S_DONE
  } state_t;

  state_t                state;
  logic [BEAT_W-1:0]     ld_left;
  logic [31:0]           q_left;
  logic [CNT_WIDTH-1:0]  cnt;
  logic                  job_ready_r;
  logic                  ld_rdy_r;
  logic                  q_rdy_r;
  logic                  done_vld_r;

  logic                  ld_hs;
  logic                  q_hs;
  logic                  resp_hit;
  logic                  resp_eos;
  logic [BEAT_W-1:0]     ld_clamp;
  logic                  cmd_vld;
  logic [3:0]            cmd_code;
  logic [511:0]          cmd_data;
  logic [C_DATA_WIDTH-1:0] cmd_word;
  logic                  unused_resp;

  assign ld_hs    = io.ld_tvalid & ld_rdy_r;
  assign q_hs     = io.q_tvalid & q_rdy_r;
  assign resp_hit = io.cam_m_tvalid && (io.cam_m_tdata[518:515] == CODE_SEARCH) && io.cam_m_tdata[0];
  assign resp_eos = io.cam_m_tvalid && (io.cam_m_tdata[518:515] == CODE_EOS);
  assign ld_clamp = (io.job_load_beats > MAX_BEATS) ? MAX_BEATS : io.job_load_beats;

  // Only the echoed state and the hit bit of a response matter here.
  assign unused_resp = ^{io.cam_m_tdata[C_DATA_WIDTH-1:519], io.cam_m_tdata[514:1]};

  // Command word. Any cycle without a command drives an all-zero word so the
  // state field can never rest on RESET_ALL, which the CAM obeys even with
  // valid low. A zero query key is swallowed the same way: empty CAM slots
  // hold 0, so searching for it would report false hits.
  always_comb begin
    cmd_vld  = 1'b0;
    cmd_code = CODE_IDLE;
    cmd_data = '0;
    case (state)
      S_CLEAR: begin
        cmd_vld  = 1'b1;
        cmd_code = CODE_RESET_ALL;
      end
      S_LOAD: begin
        if (ld_hs) begin
          cmd_vld  = 1'b1;
          cmd_code = CODE_WRITE;
          cmd_data = io.ld_tdata;
        end
      end
      S_QUERY: begin
        if (q_hs && (io.q_tdata != '0)) begin
          cmd_vld        = 1'b1;
          cmd_code       = CODE_SEARCH;
          cmd_data[31:0] = io.q_tdata;
        end
      end
      S_EOS: begin
        cmd_vld  = 1'b1;
        cmd_code = CODE_EOS;
      end
      default: ;
    endcase
  end

  always_comb begin
    cmd_word          = '0;
    cmd_word[518:515] = cmd_code;
    cmd_word[511:0]   = cmd_data;
  end

  assign io.cam_s_tvalid = cmd_vld;
  assign io.cam_s_tdata  = cmd_word;
  assign io.job_ready    = job_ready_r;
  assign io.ld_tready    = ld_rdy_r;
  assign io.q_tready     = q_rdy_r;
  assign io.done_valid   = done_vld_r;
  assign io.done_count   = cnt;

  always_ff @(posedge aclk or posedge areset) begin
    if (areset) begin
      state       <= S_IDLE;
      ld_left     <= '0;
      q_left      <= '0;
      cnt         <= '0;
      job_ready_r <= 1'b0;
      ld_rdy_r    <= 1'b0;
      q_rdy_r     <= 1'b0;
      done_vld_r  <= 1'b0;
    end else begin
      // Hits are recognised by the echoed SEARCH state, independent of the
      // CAM pipeline depth. The EOS echo never carries SEARCH, so its hit bit
      // is ignored for free.
      if (resp_hit) begin
        cnt <= cnt + 1'b1;
      end

      case (state)
        S_IDLE: begin
          job_ready_r <= 1'b1;
          if (io.job_valid && job_ready_r) begin
            job_ready_r <= 1'b0;
            ld_left     <= ld_clamp;
            q_left      <= io.job_query_cnt;
            cnt         <= '0;
            state       <= S_CLEAR;
          end
        end
        S_CLEAR: begin
          // Skip empty phases so a zero count never waits on a stream.
          if (ld_left != '0) begin
            state    <= S_LOAD;
            ld_rdy_r <= 1'b1;
          end else if (q_left != '0) begin
            state   <= S_QUERY;
            q_rdy_r <= 1'b1;
          end else begin
            state <= S_EOS;
          end
        end
        S_LOAD: begin
          if (ld_hs) begin
            ld_left <= ld_left - 1'b1;
            if (ld_left == BEAT_W'(1)) begin
              ld_rdy_r <= 1'b0;
              if (q_left != '0) begin
                state   <= S_QUERY;
                q_rdy_r <= 1'b1;
              end else begin
                state <= S_EOS;
              end
            end
          end
        end
        S_QUERY: begin
          if (q_hs) begin
            q_left <= q_left - 1'b1;
            if (q_left == 32'd1) begin
              q_rdy_r <= 1'b0;
              state   <= S_EOS;
            end
          end
        end
        S_EOS: begin
          state <= S_FLUSH;
        end
        S_FLUSH: begin
          // The EOS echo trails every search response of this job.
          if (resp_eos) begin
            state      <= S_DONE;
            done_vld_r <= 1'b1;
          end
        end
        S_DONE: begin
          if (io.done_ready) begin
            done_vld_r  <= 1'b0;
            job_ready_r <= 1'b1;
            state       <= S_IDLE;
          end
        end
        default: begin
          state <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: doc/cam_tc_sequencer.md
Name: cam_tc_sequencer

Overview:
Job-level controller for the DSP48E2 CAM array used in triangle counting. Per job it clears the CAM, loads one vertex's adjacency list, streams another list's vertex IDs as search keys, and counts CAM hits into an intersection count. It sits between the AXI-stream job, load and query sources and the 520-bit CAM command/response interface. It sequences the CAM's state field (bits [518:515]) and counts hits from result bit 0.

Parameters:
C_DATA_WIDTH, 520, CAM command/response word width.
CAM_SIZE, 128, CAM entries; must be a multiple of 16.
LANES, 16, 32-bit vertex IDs per load beat.
BEAT_W, $clog2(CAM_SIZE/LANES)+1, width of the load-beat count field.
CNT_WIDTH, 64, width of the match counter.

Ports:
aclk  in  1  clock; all logic is on the rising edge.
areset  in  1  asynchronous, active-high reset.
job_valid  in  1  job descriptor valid.
job_ready  out  1  high only in IDLE.
job_load_beats  in  BEAT_W  number of 512-bit adjacency beats to load.
job_query_cnt  in  32  number of query keys to search.
ld_tvalid  in  1  load beat valid.
ld_tready  out  1  load beat accept.
ld_tdata  in  512  16 x 32-bit vertex IDs; lane k at [32k+:32].
q_tvalid  in  1  query key valid.
q_tready  out  1  query key accept.
q_tdata  in  32  query vertex ID.
cam_s_tvalid  out  1  CAM command valid.
cam_s_tdata  out  C_DATA_WIDTH  CAM command word.
cam_m_tvalid  in  1  CAM response valid.
cam_m_tdata  in  C_DATA_WIDTH  CAM response: [518:515] is the echoed state, [0] is the hit.
done_valid  out  1  job result valid.
done_count  out  CNT_WIDTH  hits counted for the job.
done_ready  in  1  result accept.

Behaviour:
- Reset (async assert; all state updates on aclk):
  - FSM goes to IDLE.
  - All ready, valid and count outputs are 0.
  - cam_s_tdata is 0 (state IDLE=0).
- Command encoding: the state code goes to cam_s_tdata[518:515]; bits [514:512] and [519] are always 0.
- Idle command word: in any cycle with no command issued, cam_s_tvalid=0 and the state field is 0. It must never hold RESET_ALL (7), because the CAM acts on RESET_ALL without regard to valid.
- FSM states: IDLE, CLEAR, LOAD, QUERY, EOS, FLUSH, DONE.
- IDLE:
  - job_ready=1.
  - On job_valid, latch both job fields and zero the counter.
  - Latch load_beats as min(job_load_beats, CAM_SIZE/LANES).
  - Next state is CLEAR.
- CLEAR:
  - Issue exactly one word: state=7, cam_s_tvalid=1, data 0. This resets the CAM write pointer and contents to 0.
  - Next state is LOAD, or QUERY if load_beats==0.
- LOAD:
  - ld_tready=1.
  - Each handshake issues the same cycle (combinational pass-through): state=8, valid=1, [511:0]=ld_tdata.
  - After load_beats handshakes, go to QUERY, or EOS if job_query_cnt==0.
- QUERY:
  - q_tready=1.
  - Each handshake issues the same cycle: state=5, [31:0]=q_tdata.
  - cam_s_tvalid=1 only if q_tdata!=0. Key 0 is reserved: empty CAM slots hold 0, so a zero key is consumed and counted as a query but never issued.
  - After job_query_cnt handshakes, go to EOS.
- EOS: issue one word with state=F, valid=1. Next state is FLUSH.
- Hit counting (all states):
  - If cam_m_tvalid, cam_m_tdata[518:515]==5 and cam_m_tdata[0]==1, the counter increments by 1.
  - The CAM's response latency is 2 cycles. The counter logic relies only on the echoed state, not on the latency value.
- FLUSH: wait for cam_m_tvalid with echoed state F. The hit from that same response beat is ignored. Next state is DONE.
- DONE:
  - done_valid=1 and done_count holds the count; both stay stable until done_ready.
  - On the handshake, go to IDLE.
- Back-pressure:
  - Inputs are never stalled by the CAM, which has no ready.
  - ld_tready and q_tready are 0 outside LOAD and QUERY respectively.
- Reset mid-job: all state is dropped. The CAM may keep stale entries; this is safe because every job begins with CLEAR.
- Counter width: no saturation is needed, since hits ≤ job_query_cnt < 2^32.

Test Plan:
- Load/hit: load_beats=1 with lanes = 1..16, query_cnt=4 with keys {3,16,17,40}. Expect the command sequence 7, 8, then three state-5 words (keys 3, 16, 17) and one state-5 word for 40 (never a hit), then F. Expect done_count=2.
- Full CAM: load_beats=8 (IDs 1..128), then 128 queries of 1..128. Expect done_count=128. A second job with load_beats=9 clamps to 8 and accepts only 8 load beats.
- Zero key: load 1 beat with lanes 5..20, 3 queries {0,0,5}. Expect exactly one issued search and done_count=1; the bench checks cam_s_tvalid is low for the zero keys.
- Empty job: load_beats=0, query_cnt=0. Expect commands 7 then F and done_count=0. Holding done_ready=0 for 10 cycles keeps done_valid/done_count stable; job_ready=0 until the handshake.
- Gapped streams: random ld_tvalid/q_tvalid gaps. Expect no command words in gap cycles, and the state field never equals 7 except in the single CLEAR cycle.
- Reset mid-QUERY: assert areset after 2 of 5 queries. Expect all outputs 0 immediately; the next job starts with CLEAR and counts correctly.
